// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_ctrl_pkg : shared types for the memory port arbiter and response pipeline
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

  // Entry payload width; the arbiter's data width M must not exceed it.
  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    req_id_e               id;
    logic [RSP_DATA_W-1:0] data;
  } rsp_entry_t;

  function automatic rsp_entry_t kill_entry(input rsp_entry_t e,
                                            input logic       kill_en,
                                            input req_id_e    kill_id);
    rsp_entry_t r;
    r = e;
    if (kill_en && (e.id == kill_id)) r.valid = 1'b0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rsp_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsp_delay_line : LATENCY-stage response shift register with tag-based kill
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
module rsp_delay_line
  import mem_ctrl_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  rsp_entry_t in_entry,
  input  logic       kill_en,
  input  req_id_e    kill_id,
  output rsp_entry_t out_entry,
  output logic       busy
);

  rsp_entry_t stage_q [LATENCY];
  rsp_entry_t stage_d [LATENCY];

  // Kill is applied while shifting, so a matching entry is gone by the next cycle.
  always_comb begin
    stage_d[0] = kill_entry(in_entry, kill_en, kill_id);
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = kill_entry(stage_q[i-1], kill_en, kill_id);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) busy = busy | stage_q[i].valid;
  end

  assign out_entry = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : round-robin IF/LS arbiter onto one memory read/write port
// Revision         : 1.0 - initial release
// ----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int  N       = 1024,
  parameter int  M       = 32,
  parameter int  LATENCY = 2,
  localparam int AW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  input  logic          if_flush,
  output logic          if_rsp_valid,
  output logic [M-1:0]  if_rsp_data,
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic          ls_req_we,
  input  logic [AW-1:0] ls_req_addr,
  input  logic [M-1:0]  ls_req_wdata,
  output logic          ls_rsp_valid,
  output logic [M-1:0]  ls_rsp_data,
  output logic          mem_read_enable,
  output logic [AW-1:0] mem_read_addr,
  output logic          mem_write_enable,
  output logic [AW-1:0] mem_write_addr,
  output logic [M-1:0]  mem_write_data,
  input  logic [M-1:0]  mem_read_data,
  output logic          busy
);

  req_id_e    last_grant_q, last_grant_d;
  logic       if_elig, ls_elig, grant_if, grant_ls;
  rsp_entry_t in_entry, out_entry;

  // Eligibility is masked during reset so no memory access leaks out.
  always_comb begin
    if_elig  = if_req_valid & ~if_flush & ~rst;
    ls_elig  = ls_req_valid & ~rst;
    grant_if = if_elig & (~ls_elig | (last_grant_q == REQ_LS));
    grant_ls = ls_elig & (~if_elig | (last_grant_q == REQ_IF));
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_if)      last_grant_d = REQ_IF;
    else if (grant_ls) last_grant_d = REQ_LS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_LS;
    else     last_grant_q <= last_grant_d;
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    mem_read_enable  = grant_if | (grant_ls & ~ls_req_we);
    mem_read_addr    = grant_if ? if_req_addr : ls_req_addr;
    mem_write_enable = grant_ls & ls_req_we;
    mem_write_addr   = ls_req_addr;
    mem_write_data   = ls_req_wdata;
  end

  always_comb begin
    in_entry       = '0;
    in_entry.valid = grant_if | grant_ls;
    in_entry.id    = grant_if ? REQ_IF : REQ_LS;
    in_entry.data  = (grant_ls & ls_req_we) ? '0 : RSP_DATA_W'(mem_read_data);
  end

  rsp_delay_line #(
    .LATENCY (LATENCY)
  ) u_rsp_delay_line (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (in_entry),
    .kill_en   (if_flush),
    .kill_id   (REQ_IF),
    .out_entry (out_entry),
    .busy      (busy)
  );

  // A flush also hides a fetch response emerging in the same cycle.
  always_comb begin
    if_rsp_valid = out_entry.valid & (out_entry.id == REQ_IF) & ~if_flush;
    ls_rsp_valid = out_entry.valid & (out_entry.id == REQ_LS);
    if_rsp_data  = M'(out_entry.data);
    ls_rsp_data  = M'(out_entry.data);
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter (LATENCY 2 and 1)
// Revision            : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 10;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // Main DUT (LATENCY = 2)
  logic          if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [31:0]   if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [31:0]   ls_req_wdata, ls_rsp_data;
  logic          mem_read_enable, mem_write_enable, busy;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [31:0]   mem_write_data, mem_read_data;

  // Second DUT (LATENCY = 1), LS side exercised only
  logic          if_req_ready1, if_rsp_valid1;
  logic [31:0]   if_rsp_data1;
  logic          ls_req_valid1, ls_req_ready1, ls_rsp_valid1;
  logic [AW-1:0] ls_req_addr1;
  logic [31:0]   ls_rsp_data1;
  logic          mem_read_enable1, mem_write_enable1, busy1;
  logic [AW-1:0] mem_read_addr1, mem_write_addr1;
  logic [31:0]   mem_write_data1, mem_read_data1;

  logic [31:0] mem  [1024];
  logic [31:0] mem1 [1024];
  bit          mem_init = 1'b0;

  assign mem_read_data  = mem[mem_read_addr];
  assign mem_read_data1 = mem1[mem_read_addr1];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i]  <= '0;
        mem1[i] <= '0;
      end
      for (int i = 0; i < 4; i++) mem[i]       <= 32'd10  + 32'(i);
      for (int i = 0; i < 4; i++) mem[100 + i] <= 32'd200 + 32'(i);
      mem1[7]  <= 32'h55;
      mem_init <= 1'b1;
    end else begin
      if (mem_write_enable)  mem[mem_write_addr]   <= mem_write_data;
      if (mem_write_enable1) mem1[mem_write_addr1] <= mem_write_data1;
    end
  end

  mem_port_arbiter #(.N(1024), .M(32), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  mem_port_arbiter #(.N(1024), .M(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(1'b0), .if_req_ready(if_req_ready1), .if_req_addr('0),
    .if_flush(1'b0), .if_rsp_valid(if_rsp_valid1), .if_rsp_data(if_rsp_data1),
    .ls_req_valid(ls_req_valid1), .ls_req_ready(ls_req_ready1), .ls_req_we(1'b0),
    .ls_req_addr(ls_req_addr1), .ls_req_wdata('0),
    .ls_rsp_valid(ls_rsp_valid1), .ls_rsp_data(ls_rsp_data1),
    .mem_read_enable(mem_read_enable1), .mem_read_addr(mem_read_addr1),
    .mem_write_enable(mem_write_enable1), .mem_write_addr(mem_write_addr1),
    .mem_write_data(mem_write_data1), .mem_read_data(mem_read_data1), .busy(busy1)
  );

  // Scoreboard: stream 0 = IF, 1 = LS, 2 = LS of the LATENCY=1 instance
  exp_t  q [3][$];
  string nm [3] = '{"if_rsp", "ls_rsp", "ls_rsp_lat1"};

  task automatic expect_rsp(input int s, input int lat, input logic [31:0] d);
    exp_t e;
    e.cyc  = cyc + lat;
    e.data = d;
    q[s].push_back(e);
  endtask

  task automatic mon(input int s, input logic v, input logic [31:0] d);
    exp_t e;
    while (q[s].size() > 0 && q[s][0].cyc < cyc) begin
      e = q[s].pop_front();
      checks++; fails++;
      $display("FAIL %s missing: no response, required data %h in cycle %0d", nm[s], e.data, e.cyc);
    end
    if (v) begin
      checks++;
      if (q[s].size() == 0) begin
        fails++;
        $display("FAIL %s unexpected: got data %h in cycle %0d, required no response", nm[s], d, cyc);
      end else begin
        e = q[s].pop_front();
        if (e.cyc != cyc || e.data !== d) begin
          fails++;
          $display("FAIL %s: got data %h in cycle %0d, required data %h in cycle %0d",
                   nm[s], d, cyc, e.data, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_rsp_valid, if_rsp_data);
    mon(1, ls_rsp_valid, ls_rsp_data);
    mon(2, ls_rsp_valid1, ls_rsp_data1);
    if (if_rsp_valid && ls_rsp_valid) begin
      checks++; fails++;
      $display("FAIL rsp_overlap: got if and ls valid together in cycle %0d, required at most one", cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_wdata = '0;
    ls_req_valid1 = 1'b0; ls_req_addr1 = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      idle_inputs();
    end
  endtask

  task automatic ls_load(input logic [AW-1:0] a);
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = a; ls_req_wdata = '0;
  endtask

  initial begin
    int ifa;
    int lsa;
    rst = 1'b1;
    idle_inputs();

    // Reset state with both requesters asking
    step();
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    #1;
    chk("rst_if_ready", 32'(if_req_ready), 32'd0);
    chk("rst_ls_ready", 32'(ls_req_ready), 32'd0);
    chk("rst_mem_re", 32'(mem_read_enable), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'({if_rsp_valid, ls_rsp_valid, ls_rsp_valid1}), 32'd0);
    step();
    idle_inputs();
    rst = 1'b0;

    // Continuous contention: IF first, then strict alternation
    ifa = 0; lsa = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if_req_valid = 1'b1; if_req_addr = AW'(ifa);
      ls_load(AW'(100 + lsa));
      #1;
      chk("alt_if_ready", 32'(if_req_ready), 32'((k % 2) == 0));
      chk("alt_ls_ready", 32'(ls_req_ready), 32'((k % 2) == 1));
      if ((k % 2) == 0) begin
        expect_rsp(0, 2, 32'd10 + 32'(ifa));
        ifa++;
      end else begin
        expect_rsp(1, 2, 32'd200 + 32'(lsa));
        lsa++;
      end
    end
    idle(3);

    // Store then load of the same address
    step();
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 10'd5; ls_req_wdata = 32'hDEADBEEF;
    #1;
    chk("st_ready", 32'(ls_req_ready), 32'd1);
    chk("st_mem_we", 32'(mem_write_enable), 32'd1);
    chk("st_mem_re", 32'(mem_read_enable), 32'd0);
    expect_rsp(1, 2, 32'd0);
    step();
    ls_load(10'd5);
    #1;
    chk("raw_ready", 32'(ls_req_ready), 32'd1);
    chk("raw_mem_re", 32'(mem_read_enable), 32'd1);
    expect_rsp(1, 2, 32'hDEADBEEF);
    idle(4);

    // Fetch-only stream
    for (int a = 0; a < 4; a++) begin
      step();
      if_req_valid = 1'b1; if_req_addr = AW'(a);
      #1;
      chk("ifonly_ready", 32'(if_req_ready), 32'd1);
      chk("ifonly_raddr", 32'(mem_read_addr), 32'(a));
      expect_rsp(0, 2, 32'd10 + 32'(a));
    end
    idle(4);

    // Flush kills an in-flight fetch; LS load beside it survives
    step();
    if_req_valid = 1'b1; if_req_addr = 10'd0;
    #1;
    chk("fl_if_ready", 32'(if_req_ready), 32'd1);
    step();
    if_flush = 1'b1; if_req_valid = 1'b1; if_req_addr = 10'd1;
    ls_load(10'd100);
    #1;
    chk("fl_if_blocked", 32'(if_req_ready), 32'd0);
    chk("fl_ls_ready", 32'(ls_req_ready), 32'd1);
    expect_rsp(1, 2, 32'd200);
    idle(4);

    // Flush coinciding with a fetch response at the pipeline output
    step();
    if_req_valid = 1'b1; if_req_addr = 10'd1;
    #1;
    chk("fl2_if_ready", 32'(if_req_ready), 32'd1);
    idle(1);
    step();
    if_flush = 1'b1;
    idle(3);

    // Asynchronous reset with two entries in flight, last grant IF
    step();
    ls_load(10'd101);
    step();
    idle_inputs();
    if_req_valid = 1'b1; if_req_addr = 10'd2;
    #1;
    chk("mr_if_ready", 32'(if_req_ready), 32'd1);
    step();
    idle_inputs();
    chk("mr_busy_before", 32'(busy), 32'd1);
    chk("mr_ls_valid_before", 32'(ls_rsp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_busy_after", 32'(busy), 32'd0);
    chk("mr_rsp_after", 32'({if_rsp_valid, ls_rsp_valid}), 32'd0);
    step();
    rst = 1'b0;
    idle(3);
    step();
    if_req_valid = 1'b1; if_req_addr = 10'd3;
    ls_load(10'd102);
    #1;
    chk("post_rst_if_ready", 32'(if_req_ready), 32'd1);
    chk("post_rst_ls_ready", 32'(ls_req_ready), 32'd0);
    expect_rsp(0, 2, 32'd13);
    step();
    if_req_valid = 1'b0;
    #1;
    chk("post_rst_ls_next", 32'(ls_req_ready), 32'd1);
    expect_rsp(1, 2, 32'd202);
    idle(4);

    // LATENCY = 1 instance
    step();
    ls_req_valid1 = 1'b1; ls_req_addr1 = 10'd7;
    #1;
    chk("lat1_ready", 32'(ls_req_ready1), 32'd1);
    expect_rsp(2, 1, 32'h55);
    idle(4);

    for (int s = 0; s < 3; s++) chk({"drain_", nm[s]}, 32'(q[s].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port-pair memory instance (combinational read port, synchronous write port) between the instruction-fetch (IF) and load/store (LS) requesters of the in-order single-issue core.
- Round-robin arbitration, one request accepted per cycle.
- Models the memory's read latency with a LATENCY-deep response pipeline.
- Supports an IF flush that kills in-flight fetch responses.

Parameters:
- N, 1024: memory depth in words; address width AW = $clog2(N).
- M, 32: data width.
- LATENCY, 2: cycles from request acceptance to response; legal range is LATENCY >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  AW  fetch word address
- if_flush  in  1  kill all in-flight fetch responses
- if_rsp_valid  out  1  fetch data valid (single-cycle pulse)
- if_rsp_data  out  M  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_addr  in  AW  load/store word address
- ls_req_wdata  in  M  store data
- ls_rsp_valid  out  1  load data, or store completion (single-cycle pulse)
- ls_rsp_data  out  M  load data; '0 for stores
- mem_read_enable  out  1  to memory
- mem_read_addr  out  AW  to memory
- mem_write_enable  out  1  to memory
- mem_write_addr  out  AW  to memory
- mem_write_data  out  M  to memory
- mem_read_data  in  M  from memory, combinational
- busy  out  1  any response entry in flight

Behaviour:
- Reset (asynchronous): all pipeline valid bits 0; last_grant = LS, so IF wins the first contention. All rsp_valid, busy and mem enables read 0 while rst is high.
- Arbitration is combinational each cycle:
  - Only one requester valid: it is granted.
  - Both valid: the requester not in last_grant is granted.
  - if_flush=1 forces IF ineligible that cycle.
- ready = granted. Acceptance = valid && ready. last_grant updates only on acceptance.
- Ready depends on valid of both requesters. Requesters must not make valid depend on ready.
- Accepted load/fetch in cycle t:
  - mem_read_enable=1 and mem_read_addr=addr in cycle t.
  - mem_read_data is captured at the end of cycle t into stage 1 with tag {IF|LS}.
  - Response is valid during cycle t+LATENCY.
- Accepted store in cycle t:
  - mem_write_enable=1 in cycle t with the given address and data; memory is updated at the end of cycle t.
  - A completion entry (data '0, tag LS) is inserted and ls_rsp_valid pulses in cycle t+LATENCY.
- Idle cycles: mem enables 0; addresses and write data are don't-care but driven from the LS inputs.
- Pipeline shifts every cycle with no back-pressure. Capacity is therefore LATENCY entries, and ready is never stalled by the pipeline.
- Responses come out in acceptance order. An IF response and an LS response never occur in the same cycle.
- Read-after-write: a load accepted in cycle t+1 returns data written in cycle t. A same-cycle read and write cannot occur (single grant).
- Flush:
  - if_flush in cycle t clears valid on all IF-tagged entries at the end of cycle t.
  - if_rsp_valid is gated to 0 in cycle t.
  - LS entries are unaffected.
- busy = OR of pipeline valid bits.
- Reset mid-operation drops all in-flight responses. No response is produced after reset deasserts for any pre-reset request.

Decomposition:
- Package mem_ctrl_pkg:
  - req_id_e {REQ_IF, REQ_LS}
  - rsp_entry_t struct {valid, id, data[M-1:0]}; it is parameterized by M, so it is declared as a localparam-width field or by the default width 32.
- Submodule rsp_delay_line: LATENCY-stage shift register of rsp_entry_t with asynchronous reset and a kill_id/kill_en input that clears matching valid bits.
- The top level holds only the arbiter and the memory-port muxing.

Test Plan:
- Store 0xDEADBEEF to addr 5 in cycle 0, then load addr 5 in cycle 1 -> ls_rsp_valid in cycle 2 (store completion, data 0) and in cycle 3 with data 0xDEADBEEF.
- IF and LS both valid continuously from reset, IF addrs 0,1,2,... and LS loads at 100,... -> grants alternate IF, LS, IF, LS starting with IF; each response appears exactly 2 cycles after its grant.
- Only IF valid for 4 cycles (addrs 0-3 preloaded 10,11,12,13) -> ready=1 each cycle; if_rsp_data = 10,11,12,13 in cycles 2-5; ls_rsp_valid never 1.
- Fetches accepted in cycles 0 and 1 and an LS load in cycle 1 is impossible (single grant); instead issue IF cycle 0, LS load cycle 1, and assert if_flush in cycle 1 -> no if_rsp_valid in cycles 1-3; ls_rsp_valid in cycle 3.
- rst asserted asynchronously mid-cycle with 2 entries in flight -> busy and all rsp_valid drop to 0 immediately; after release, no stale responses; the first contention is granted to IF.
- LATENCY=1 build, load addr 7 (value 0x55) -> ls_rsp_valid and data 0x55 in the cycle after acceptance.
